// File: rtl/scalar_mul_ram_sequencer_if.sv
// Bus bundle between the sequencer, RAM port B and the scalar-mul core.
// Latency: none (wires only).
// Backpressure: none; the RAM and core are always ready, the core answers with a done pulse.
// Ports (master = sequencer view):
//   command / status          : control and status words shared with the RAM block
//   b_w, b_adbus, b_data_in   : RAM port-B write enable, address, write data (out)
//   b_data_out                : RAM port-B read data, one cycle after address (in)
//   core_start, core_k/px/py  : core launch pulse and registered operands (out)
//   core_done, core_qx/qy     : core completion pulse and result (in)
interface scalar_mul_ram_sequencer_if #(
   parameter int Data = 256,
   parameter int Addr = 5
);
   logic [Data-1:0] command;
   logic [Data-1:0] status;
   logic            b_w;
   logic [Addr:0]   b_adbus;
   logic [Data-1:0] b_data_in;
   logic [Data-1:0] b_data_out;
   logic            core_start;
   logic [Data-1:0] core_k;
   logic [Data-1:0] core_px;
   logic [Data-1:0] core_py;
   logic            core_done;
   logic [Data-1:0] core_qx;
   logic [Data-1:0] core_qy;

   modport master (
      input  command,
      output status,
      output b_w, b_adbus, b_data_in,
      input  b_data_out,
      output core_start, core_k, core_px, core_py,
      input  core_done, core_qx, core_qy
   );

   modport slave (
      output command,
      input  status,
      input  b_w, b_adbus, b_data_in,
      output b_data_out,
      input  core_start, core_k, core_px, core_py,
      output core_done, core_qx, core_qy
   );
endinterface

// File: rtl/scalar_mul_ram_sequencer.sv
// Port-B master: fetches k/Px/Py from RAM, runs the scalar-mul core, writes Qx/Qy back, reports status.
// Latency: start edge to core_start 5 cycles; core_done to status.done 4 cycles.
// Backpressure: none; start edges outside IDLE are dropped, a watchdog bounds the wait for the core.
// Ports: clk, rst (async active-high); bus = scalar_mul_ram_sequencer_if.master carrying
//   command/status words, RAM port B (b_w/b_adbus/b_data_in/b_data_out) and the core
//   handshake (core_start/core_k/core_px/core_py, core_done/core_qx/core_qy).
module scalar_mul_ram_sequencer #(
   parameter int          Data    = 256,
   parameter int          Addr    = 5,
   parameter int          K_ADDR  = 1,
   parameter int          PX_ADDR = 2,
   parameter int          PY_ADDR = 3,
   parameter int          QX_ADDR = 4,
   parameter int          QY_ADDR = 5,
   parameter int unsigned TIMEOUT = 2**20
) (
   input  logic                          clk,
   input  logic                          rst,
   scalar_mul_ram_sequencer_if.master    bus
);

   localparam logic [Addr:0] K_A       = (Addr+1)'(K_ADDR);
   localparam logic [Addr:0] PX_A      = (Addr+1)'(PX_ADDR);
   localparam logic [Addr:0] PY_A      = (Addr+1)'(PY_ADDR);
   localparam logic [Addr:0] QX_A      = (Addr+1)'(QX_ADDR);
   localparam logic [Addr:0] QY_A      = (Addr+1)'(QY_ADDR);
   localparam logic [31:0]   WDOG_LAST = 32'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_K, S_RD_PX, S_RD_PY, S_CAP_PY,
      S_START, S_WAIT, S_WR_QX, S_WR_QY, S_FIN
   } state_t;

   state_t          state_q, state_d;
   logic            start_prev_q, start_prev_d;
   logic [31:0]     wdog_q, wdog_d;
   logic [Data-1:0] core_k_q, core_k_d;
   logic [Data-1:0] core_px_q, core_px_d;
   logic [Data-1:0] core_py_q, core_py_d;
   logic [Data-1:0] qx_q, qx_d;
   logic [Data-1:0] qy_q, qy_d;
   // {err_timeout, err_k0, done, busy}
   logic [3:0]      status_q, status_d;

   logic            start_edge;
   logic            b_w_c;
   logic [Addr:0]   b_adbus_c;
   logic [Data-1:0] b_data_in_c;
   logic            core_start_c;

   // Only bits [1:0] of the command word carry meaning.
   logic            unused_cmd;
   assign unused_cmd = ^bus.command[Data-1:2];

   assign start_edge = bus.command[0] & ~start_prev_q;

   always_comb begin
      state_d      = state_q;
      start_prev_d = bus.command[0];
      wdog_d       = wdog_q;
      core_k_d     = core_k_q;
      core_px_d    = core_px_q;
      core_py_d    = core_py_q;
      qx_d         = qx_q;
      qy_d         = qy_q;
      status_d     = status_q;
      b_w_c        = 1'b0;
      b_adbus_c    = '0;
      b_data_in_c  = '0;
      core_start_c = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Start beats clear: acceptance already wipes the sticky flags.
            if (start_edge) begin
               status_d = 4'b0001;
               state_d  = S_RD_K;
            end else if (bus.command[1]) begin
               status_d[3:1] = 3'b000;
            end
         end
         // Synchronous RAM: each word is captured one state after its address is driven.
         S_RD_K: begin
            b_adbus_c = K_A;
            state_d   = S_RD_PX;
         end
         S_RD_PX: begin
            b_adbus_c = PX_A;
            core_k_d  = bus.b_data_out;
            state_d   = S_RD_PY;
         end
         S_RD_PY: begin
            b_adbus_c = PY_A;
            core_px_d = bus.b_data_out;
            state_d   = S_CAP_PY;
         end
         S_CAP_PY: begin
            core_py_d = bus.b_data_out;
            if (core_k_q == '0) begin
               status_d[2] = 1'b1;
               state_d     = S_FIN;
            end else begin
               state_d = S_START;
            end
         end
         S_START: begin
            core_start_c = 1'b1;
            wdog_d       = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_q + 32'd1;
            // A result arriving on the final watchdog cycle is still taken.
            if (bus.core_done) begin
               qx_d    = bus.core_qx;
               qy_d    = bus.core_qy;
               state_d = S_WR_QX;
            end else if (wdog_q == WDOG_LAST) begin
               status_d[3] = 1'b1;
               state_d     = S_FIN;
            end
         end
         S_WR_QX: begin
            b_w_c       = 1'b1;
            b_adbus_c   = QX_A;
            b_data_in_c = qx_q;
            state_d     = S_WR_QY;
         end
         S_WR_QY: begin
            b_w_c       = 1'b1;
            b_adbus_c   = QY_A;
            b_data_in_c = qy_q;
            state_d     = S_FIN;
         end
         S_FIN: begin
            status_d[0] = 1'b0;
            status_d[1] = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // start_prev resets high so a start bit already set at reset release is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         start_prev_q <= 1'b1;
         wdog_q       <= '0;
         core_k_q     <= '0;
         core_px_q    <= '0;
         core_py_q    <= '0;
         qx_q         <= '0;
         qy_q         <= '0;
         status_q     <= '0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         wdog_q       <= wdog_d;
         core_k_q     <= core_k_d;
         core_px_q    <= core_px_d;
         core_py_q    <= core_py_d;
         qx_q         <= qx_d;
         qy_q         <= qy_d;
         status_q     <= status_d;
      end
   end

   // Port-B and core_start decode straight from state, so reset zeroes them in the same cycle.
   assign bus.b_w        = b_w_c;
   assign bus.b_adbus    = b_adbus_c;
   assign bus.b_data_in  = b_data_in_c;
   assign bus.core_start = core_start_c;
   assign bus.core_k     = core_k_q;
   assign bus.core_px    = core_px_q;
   assign bus.core_py    = core_py_q;
   assign bus.status     = {{(Data-4){1'b0}}, status_q};

endmodule

// File: tb/tb_scalar_mul_ram_sequencer.sv
// Bench for scalar_mul_ram_sequencer: RAM model on port B, table of runs plus hand-written corner sequences.
// Latency: checks the 5-cycle launch and 4-cycle done latencies.
// Backpressure: none; the core responder pulses core_done a vector-defined number of cycles after core_start.
module tb_scalar_mul_ram_sequencer;

   localparam logic [255:0] SENT4 = 256'hDEAD_0004;
   localparam logic [255:0] SENT5 = 256'hDEAD_0005;

   typedef struct {
      logic [1:0]   cmd;
      logic [255:0] k;
      logic [255:0] px;
      logic [255:0] py;
      int           dly;      // cycles from core_start to core_done; -1 = never
      logic [255:0] qx;
      logic [255:0] qy;
      logic [3:0]   exp_st;
      bit           exp_run;
      bit           exp_wr;
   } vec_t;

   typedef struct {
      logic [255:0] k;
      logic [255:0] px;
      logic [255:0] py;
   } ops_t;

   typedef struct {
      logic [5:0]   a;
      logic [255:0] d;
   } wr_t;

   logic clk;
   logic rst;

   scalar_mul_ram_sequencer_if #(.Data(256), .Addr(5)) sif ();

   scalar_mul_ram_sequencer #(
      .Data(256), .Addr(5), .K_ADDR(1), .PX_ADDR(2), .PY_ADDR(3),
      .QX_ADDR(4), .QY_ADDR(5), .TIMEOUT(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: host writes model port A, sequencer uses port B.
   logic [255:0] ram [0:63];
   logic         host_we;
   logic [5:0]   host_addr;
   logic [255:0] host_dat;

   always @(posedge clk) begin
      if (host_we) ram[host_addr] <= host_dat;
      if (sif.b_w) ram[sif.b_adbus] <= sif.b_data_in;
      sif.b_data_out <= ram[sif.b_adbus];
   end

   vec_t vecs [5];
   ops_t op_q [$];
   wr_t  wr_q [$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int cs_count = 0;
   int cs_cyc = 0;
   bit cs_pending = 0;
   int core_dly = -1;
   int done_cyc = 0;
   int start_cyc = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // One clock: respond as the core after the edge, then observe outputs on the falling edge.
   task automatic step();
      ops_t e;
      wr_t  w;
      @(posedge clk);
      cyc++;
      #1;
      sif.core_done = cs_pending && (core_dly >= 0) && (cyc == cs_cyc + core_dly);
      if (sif.core_done) begin
         cs_pending = 0;
         done_cyc   = cyc;
      end
      @(negedge clk);
      if (sif.core_start === 1'b1) begin
         cs_count++;
         cs_cyc     = cyc;
         cs_pending = 1;
         if (op_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_core_start at cycle %0d", cyc);
         end else begin
            e = op_q.pop_front();
            check("core_k", sif.core_k, e.k);
            check("core_px", sif.core_px, e.px);
            check("core_py", sif.core_py, e.py);
         end
      end
      if (sif.b_w === 1'b1) begin
         if (wr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write addr %0d at cycle %0d", sif.b_adbus, cyc);
         end else begin
            w = wr_q.pop_front();
            check("wr_addr", {250'b0, sif.b_adbus}, {250'b0, w.a});
            check("wr_data", sif.b_data_in, w.d);
         end
      end
   endtask

   task automatic host_write(input logic [5:0] a, input logic [255:0] d);
      host_we   = 1'b1;
      host_addr = a;
      host_dat  = d;
      step();
      host_we   = 1'b0;
   endtask

   // Load operands and push what the DUT must produce for this run.
   task automatic prep(input vec_t v);
      host_write(6'd1, v.k);
      host_write(6'd2, v.px);
      host_write(6'd3, v.py);
      host_write(6'd4, SENT4);
      host_write(6'd5, SENT5);
      if (v.exp_run) op_q.push_back('{k: v.k, px: v.px, py: v.py});
      if (v.exp_wr) begin
         wr_q.push_back('{a: 6'd4, d: v.qx});
         wr_q.push_back('{a: 6'd5, d: v.qy});
      end
      sif.core_qx = v.qx;
      sif.core_qy = v.qy;
      core_dly    = v.dly;
      cs_pending  = 0;
      cs_count    = 0;
   endtask

   task automatic wait_fin(output bit ok, output int fcyc);
      ok   = 0;
      fcyc = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sif.status[1] === 1'b1 && sif.status[0] === 1'b0) begin
            ok   = 1;
            fcyc = cyc;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit ok;
      int fcyc;
      prep(v);
      start_cyc   = cyc;
      sif.command = {254'b0, v.cmd};
      step();
      check($sformatf("v%0d_accept_status", idx), sif.status, 256'h1);
      wait_fin(ok, fcyc);
      check($sformatf("v%0d_finished", idx), {255'b0, ok}, 256'd1);
      check($sformatf("v%0d_status", idx), sif.status, {252'b0, v.exp_st});
      check($sformatf("v%0d_core_starts", idx), cs_count, v.exp_run ? 1 : 0);
      if (v.exp_run)
         check($sformatf("v%0d_start_latency", idx), cs_cyc - start_cyc, 5);
      if (v.exp_wr)
         check($sformatf("v%0d_done_latency", idx), fcyc - done_cyc, 4);
      check($sformatf("v%0d_ram4", idx), ram[4], v.exp_wr ? v.qx : SENT4);
      check($sformatf("v%0d_ram5", idx), ram[5], v.exp_wr ? v.qy : SENT5);
      check($sformatf("v%0d_ops_left", idx), op_q.size(), 0);
      check($sformatf("v%0d_writes_left", idx), wr_q.size(), 0);
      sif.command = '0;
      step();
   endtask

   initial begin
      bit ok;
      int fcyc;

      vecs[0] = '{cmd: 2'b01, k: 256'd5, px: 256'h11, py: 256'h22, dly: 10,
                  qx: 256'hAA, qy: 256'hBB, exp_st: 4'b0010, exp_run: 1'b1, exp_wr: 1'b1};
      vecs[1] = '{cmd: 2'b01, k: 256'd0, px: 256'h33, py: 256'h44, dly: 10,
                  qx: 256'h99, qy: 256'h98, exp_st: 4'b0110, exp_run: 1'b0, exp_wr: 1'b0};
      vecs[2] = '{cmd: 2'b01, k: 256'd7, px: 256'h1, py: 256'h2, dly: -1,
                  qx: 256'h77, qy: 256'h78, exp_st: 4'b1010, exp_run: 1'b1, exp_wr: 1'b0};
      vecs[3] = '{cmd: 2'b01, k: 256'd9, px: 256'h3, py: 256'h4, dly: 16,
                  qx: 256'hCC, qy: 256'hDD, exp_st: 4'b0010, exp_run: 1'b1, exp_wr: 1'b1};
      vecs[4] = '{cmd: 2'b11,
                  k:  {64'hFEDC_BA98_7654_3210, 64'h0, 64'h1, 64'h8000_0000_0000_0001},
                  px: {4{64'h0123_4567_89AB_CDEF}},
                  py: {4{64'hFEDC_BA98_7654_3210}},
                  dly: 1,
                  qx: {4{64'hA5A5_A5A5_A5A5_A5A5}},
                  qy: {4{64'h5A5A_5A5A_5A5A_5A5A}},
                  exp_st: 4'b0010, exp_run: 1'b1, exp_wr: 1'b1};

      // Reset with start already high: outputs zero, no run after release.
      rst         = 1'b1;
      sif.command = 256'h1;
      sif.core_done = 1'b0;
      sif.core_qx = '0;
      sif.core_qy = '0;
      host_we     = 1'b0;
      host_addr   = '0;
      host_dat    = '0;
      step();
      step();
      check("rst_status", sif.status, 256'h0);
      check("rst_b_w", {255'b0, sif.b_w}, 256'h0);
      check("rst_b_adbus", {250'b0, sif.b_adbus}, 256'h0);
      check("rst_b_data_in", sif.b_data_in, 256'h0);
      check("rst_core_start", {255'b0, sif.core_start}, 256'h0);
      check("rst_core_k", sif.core_k, 256'h0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("rst_release_no_run", cs_count, 0);
      check("rst_release_idle", sif.status, 256'h0);
      sif.command = '0;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Clear after an error leaves status empty.
      run_vec(vecs[2], 10);
      sif.command = 256'h2;
      step();
      check("clear_status", sif.status, 256'h0);
      sif.command = '0;
      step();

      // Start held through completion, with a second edge while busy: one run only.
      prep(vecs[0]);
      sif.command = 256'h1;
      for (int i = 0; i < 20 && cs_count == 0; i++) step();
      sif.command = '0;
      step();
      sif.command = 256'h1;
      wait_fin(ok, fcyc);
      check("hold_finished", {255'b0, ok}, 256'd1);
      for (int i = 0; i < 10; i++) step();
      check("hold_one_run", cs_count, 1);
      check("hold_status", sif.status, 256'h2);
      check("hold_writes_left", wr_q.size(), 0);
      sif.command = '0;
      step();
      run_vec(vecs[1], 20);
      run_vec(vecs[0], 21);

      // Reset in WAIT aborts at once; held start does not relaunch.
      prep(vecs[2]);
      sif.command = 256'h1;
      for (int i = 0; i < 20 && cs_count == 0; i++) step();
      step();
      step();
      rst = 1'b1;
      #1;
      check("abort_status", sif.status, 256'h0);
      check("abort_b_w", {255'b0, sif.b_w}, 256'h0);
      check("abort_b_adbus", {250'b0, sif.b_adbus}, 256'h0);
      check("abort_core_start", {255'b0, sif.core_start}, 256'h0);
      check("abort_core_k", sif.core_k, 256'h0);
      check("abort_core_px", sif.core_px, 256'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("abort_no_relaunch", cs_count, 1);
      check("abort_idle_status", sif.status, 256'h0);
      check("abort_ram4", ram[4], SENT4);
      sif.command = '0;
      step();
      run_vec(vecs[0], 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
